// File: rtl/tt_um_mux_sweep_seq.sv
// Stimulus/check sequencer for the 2:1 mux tile: sweeps {b,sel,a} over all eight patterns and
// compares ui_in[2] against sel ? b : a. Define MUX_SEQ_FIRST_FAIL_EN for first-fail capture on uio_out.
module tt_um_mux_sweep_seq #(
  parameter int SETTLE_W    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

`ifdef MUX_SEQ_FIRST_FAIL_EN
  localparam int ERR_W = 4;
`else
  localparam int ERR_W = 8;
`endif

  // Handshake: none. start is a level input; only a synchronized 0->1 transition outside
  // a sweep starts one. Outputs are plain status levels sampled by the host at leisure.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] start_sync_q;
  logic [SYNC_STAGES-1:0] mode_sync_q;
  logic                   start_prev_q;
  logic [2:0]             vec_q;
  logic [SETTLE_W-1:0]    settle_n_q;
  logic [SETTLE_W-1:0]    cnt_q;
  logic [ERR_W-1:0]       err_q;
  logic [ERR_W-1:0]       err_d;
  logic                   busy_q;
  logic                   done_q;
  logic                   pass_q;
`ifdef MUX_SEQ_FIRST_FAIL_EN
  logic                   ff_valid_q;
  logic [2:0]             ff_vec_q;
`endif

  logic                   start_rise;
  logic                   mode_s;
  logic                   expected;
  logic                   mismatch;
  logic [SETTLE_W-1:0]    settle_in;
  logic                   unused_inputs;

  assign unused_inputs = ^{uio_in, ui_in[3]};

  assign settle_in  = ui_in[4 +: SETTLE_W];
  assign start_rise = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
  assign mode_s     = mode_sync_q[SYNC_STAGES-1];
  assign expected   = vec_q[1] ? vec_q[2] : vec_q[0];
  assign mismatch   = (state_q == CHECK) && (ui_in[2] != expected);

  always_comb begin
    err_d = err_q;
    if (mismatch && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  // Start synchronizer resets to all-ones so a start held high through reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_sync_q <= '1;
      mode_sync_q  <= '0;
      start_prev_q <= 1'b1;
      vec_q        <= 3'd0;
      settle_n_q   <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
`ifdef MUX_SEQ_FIRST_FAIL_EN
      ff_valid_q   <= 1'b0;
      ff_vec_q     <= 3'd0;
`endif
    end else if (ena) begin
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], ui_in[0]};
      mode_sync_q  <= {mode_sync_q[SYNC_STAGES-2:0], ui_in[1]};
      start_prev_q <= start_sync_q[SYNC_STAGES-1];
      case (state_q)
        IDLE, DONE: begin
          if (start_rise) begin
            state_q    <= SETTLE;
            vec_q      <= 3'd0;
            err_q      <= '0;
            settle_n_q <= settle_in;
            cnt_q      <= settle_in;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef MUX_SEQ_FIRST_FAIL_EN
            ff_valid_q <= 1'b0;
            ff_vec_q   <= 3'd0;
`endif
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q - SETTLE_W'(1);
          end
        end
        CHECK: begin
          err_q <= err_d;
`ifdef MUX_SEQ_FIRST_FAIL_EN
          if (mismatch && !ff_valid_q) begin
            ff_valid_q <= 1'b1;
            ff_vec_q   <= vec_q;
          end
`endif
          if (vec_q != 3'd7) begin
            vec_q   <= vec_q + 3'd1;
            cnt_q   <= settle_n_q;
            state_q <= SETTLE;
          end else if (mode_s) begin
            vec_q   <= 3'd0;
            cnt_q   <= settle_n_q;
            state_q <= SETTLE;
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uo_out = {2'b00, pass_q, done_q, busy_q, (busy_q ? vec_q : 3'b000)};
  assign uio_oe = 8'hFF;

`ifdef MUX_SEQ_FIRST_FAIL_EN
  assign uio_out = {ff_valid_q, ff_vec_q, err_q};
`else
  assign uio_out = err_q;
`endif

endmodule
